// File: rtl/controller_interface_m.sv
// ---------------------------------------------------------------------------
// controller_interface_m
//
// Polls two NES-style serial game controllers (4021 parallel-in / serial-out
// shift registers) and exposes their button states as two read-only CPU
// registers: 0x7002 (controller 1) and 0x7003 (controller 2). The address
// decoder selects the register; this block only supplies the byte.
//
// A poll is a fixed sequence: a latch strobe of 2*CLK_DIV cycles, then eight
// serial bits of 2*CLK_DIV cycles each (low half, then high half of the shift
// clock), then a single commit cycle that copies both shift registers into
// the button registers at once. The CPU therefore never sees a partially
// shifted value.
//
// Parameters
//   CLK_DIV              system-clock cycles per half period of the shift
//                        clock (1 or greater)
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous, active-high reset
//   start_i              single-cycle poll request, honoured only when idle
//   controller_data_1_i  serial data from controller 1, active low
//   controller_data_2_i  serial data from controller 2, active low
//   controller_latch_o   parallel-load strobe to both controllers
//   controller_clk_o     shift clock to both controllers
//   busy_o               high while a poll is in progress (through commit)
//   SELECT_controller_1  decoder select for 0x7002
//   SELECT_controller_2  decoder select for 0x7003
//   cpu_data_o           combinational read data to the CPU bus
// ---------------------------------------------------------------------------
module controller_interface_m #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       controller_data_1_i,
    input  logic       controller_data_2_i,
    output logic       controller_latch_o,
    output logic       controller_clk_o,
    output logic       busy_o,
    input  logic       SELECT_controller_1,
    input  logic       SELECT_controller_2,
    output logic [7:0] cpu_data_o
);

    // The divider spans one full bit period (low half plus high half).
    localparam int DIV_W = $clog2(2 * CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LOW_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HIGH_FIRST = DIV_W'(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SHIFT,
        COMMIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_count;
    logic [DIV_W-1:0] div_next;
    logic [2:0]       bit_count;
    logic [2:0]       bit_next;
    logic [7:0]       shift_1;
    logic [7:0]       shift_1_next;
    logic [7:0]       shift_2;
    logic [7:0]       shift_2_next;
    logic [7:0]       buttons_1;
    logic [7:0]       buttons_1_next;
    logic [7:0]       buttons_2;
    logic [7:0]       buttons_2_next;
    logic             latch_next;
    logic             sclk_next;
    logic             busy_next;

    // Next-state and next-output logic. The divider runs 0..2*CLK_DIV-1 in
    // both LATCH and SHIFT. In SHIFT the lower half of that range is the low
    // phase of the shift clock and the upper half is the high phase. Data is
    // sampled on the last low-phase cycle, one cycle before the controllers
    // see their rising shift edge, so the bit being captured is the one the
    // controller presented after the previous rising edge (or after latch).
    //
    // The registered outputs are derived from the state and divider value
    // that will hold next cycle, which keeps latch/clk/busy exactly aligned
    // with the phase they describe without separate bookkeeping.
    always_comb begin
        state_next     = state;
        div_next       = div_count;
        bit_next       = bit_count;
        shift_1_next   = shift_1;
        shift_2_next   = shift_2;
        buttons_1_next = buttons_1;
        buttons_2_next = buttons_2;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = LATCH;
                    div_next   = '0;
                end
            end

            LATCH: begin
                if (div_count == DIV_LAST) begin
                    state_next = SHIFT;
                    div_next   = '0;
                    bit_next   = 3'd0;
                end else begin
                    div_next = div_count + 1'b1;
                end
            end

            SHIFT: begin
                if (div_count == LOW_LAST) begin
                    shift_1_next = {shift_1[6:0], ~controller_data_1_i};
                    shift_2_next = {shift_2[6:0], ~controller_data_2_i};
                end

                if (div_count == DIV_LAST) begin
                    div_next = '0;
                    if (bit_count == 3'd7) begin
                        state_next = COMMIT;
                    end else begin
                        bit_next = bit_count + 3'd1;
                    end
                end else begin
                    div_next = div_count + 1'b1;
                end
            end

            COMMIT: begin
                buttons_1_next = shift_1;
                buttons_2_next = shift_2;
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        latch_next = (state_next == LATCH);
        sclk_next  = (state_next == SHIFT) && (div_next >= HIGH_FIRST);
        busy_next  = (state_next != IDLE);
    end

    // State, counters, data registers and the controller-facing outputs.
    // Reset aborts any poll in flight; the button registers are cleared
    // rather than left at their last committed value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            div_count          <= '0;
            bit_count          <= 3'd0;
            shift_1            <= 8'h00;
            shift_2            <= 8'h00;
            buttons_1          <= 8'h00;
            buttons_2          <= 8'h00;
            controller_latch_o <= 1'b0;
            controller_clk_o   <= 1'b0;
            busy_o             <= 1'b0;
        end else begin
            state              <= state_next;
            div_count          <= div_next;
            bit_count          <= bit_next;
            shift_1            <= shift_1_next;
            shift_2            <= shift_2_next;
            buttons_1          <= buttons_1_next;
            buttons_2          <= buttons_2_next;
            controller_latch_o <= latch_next;
            controller_clk_o   <= sclk_next;
            busy_o             <= busy_next;
        end
    end

    // CPU read mux. The decoder never asserts both selects; if it ever did,
    // ORing the two registers is the harmless choice for a wired bus.
    always_comb begin
        cpu_data_o = 8'h00;
        case ({SELECT_controller_2, SELECT_controller_1})
            2'b01:   cpu_data_o = buttons_1;
            2'b10:   cpu_data_o = buttons_2;
            2'b11:   cpu_data_o = buttons_1 | buttons_2;
            default: cpu_data_o = 8'h00;
        endcase
    end

endmodule
